// File: rtl/memory_access_if.sv
// Data-memory req/ack port between the MEM stage (master) and the data memory (slave).
interface memory_access_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    dmem_req;
  logic                    dmem_we;
  logic [ADDR_WIDTH-1:0]   dmem_addr;
  logic [DATA_WIDTH-1:0]   dmem_wdata;
  logic [DATA_WIDTH/8-1:0] dmem_be;
  logic                    dmem_ack;
  logic [DATA_WIDTH-1:0]   dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/memory_access.sv
// MEM pipeline stage: byte-lane steering, req/ack data-memory access, load extension, MEM/WB register.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of forcing them aligned.
module memory_access #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  input  logic [DATA_WIDTH-1:0] i_write_data,
  input  logic [2:0]            i_funct3,
  input  logic [4:0]            i_rd,
  input  logic                  ctrl_mem_read,
  input  logic                  ctrl_mem_write,
  input  logic                  ctrl_reg_write,
  memory_access_if.master       dmem,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic [4:0]            o_rd,
  output logic                  o_reg_write,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic                  o_misaligned,
`endif
  output logic                  stall
);

  typedef enum logic {IDLE, BUSY} state_e;
  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} size_e;

  // funct3[1:0] picks the size; 011/110/111 fall through to a full word.
  function automatic size_e decode_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  state_e                state, next_state;
  size_e                 in_size;
  logic [1:0]            in_off;
  logic [3:0]            in_be;
  logic [DATA_WIDTH-1:0] in_wdata;
  logic                  mem_op;
  logic                  trap;
  logic                  accept;
  logic                  start_mem;

  size_e                 size_q;
  logic                  unsigned_q;
  logic [1:0]            off_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [4:0]            rd_q;
  logic                  reg_write_q;
  logic [DATA_WIDTH-1:0] rdata_shift;
  logic [DATA_WIDTH-1:0] load_ext;

  // Request decode: effective lane offset, byte enables and replicated store data.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    in_size  = decode_size(i_funct3);
    in_off   = i_alu_result[1:0];
    in_be    = 4'b1111;
    in_wdata = i_write_data;
    case (in_size)
      SZ_B: begin
        in_be    = 4'b0001 << in_off;
        in_wdata = {4{i_write_data[7:0]}};
      end
      SZ_H: begin
        in_off   = {i_alu_result[1], 1'b0};
        in_be    = 4'b0011 << in_off;
        in_wdata = {2{i_write_data[15:0]}};
      end
      default: begin
        in_off = 2'b00;
      end
    endcase
  end

  assign mem_op = ctrl_mem_read | ctrl_mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = mem_op && (((in_size == SZ_H) && i_alu_result[0]) ||
                           ((in_size == SZ_W) && (i_alu_result[1:0] != 2'b00)));
`else
  assign trap = 1'b0;
`endif

  assign accept    = (state == IDLE) && i_valid;
  assign start_mem = accept && mem_op && !trap;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_mem)     next_state = BUSY;
      BUSY:    if (dmem.dmem_ack) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Moore/Mealy outputs; stall releases in the ack cycle itself.
  always_comb begin
    dmem.dmem_req = (state == BUSY);
    stall         = (state == BUSY) && !dmem.dmem_ack;
  end

  // Load alignment and sign/zero extension from the latched offset and size.
  always_comb begin
    rdata_shift = dmem.dmem_rdata >> {off_q, 3'b000};
    case (size_q)
      SZ_B:    load_ext = unsigned_q ? {24'b0, rdata_shift[7:0]}
                                     : {{24{rdata_shift[7]}}, rdata_shift[7:0]};
      SZ_H:    load_ext = unsigned_q ? {16'b0, rdata_shift[15:0]}
                                     : {{16{rdata_shift[15]}}, rdata_shift[15:0]};
      default: load_ext = rdata_shift;
    endcase
  end

  // Memory-port registers, access context and the MEM/WB register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_wdata <= '0;
      dmem.dmem_be    <= '0;
      size_q          <= SZ_B;
      unsigned_q      <= 1'b0;
      off_q           <= 2'b00;
      addr_q          <= '0;
      rd_q            <= '0;
      reg_write_q     <= 1'b0;
      o_valid         <= 1'b0;
      o_result        <= '0;
      o_rd            <= '0;
      o_reg_write     <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      o_misaligned    <= 1'b0;
`endif
    end else begin
      o_valid     <= 1'b0;
      o_reg_write <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      o_misaligned <= 1'b0;
`endif
      if (start_mem) begin
        dmem.dmem_we    <= ctrl_mem_write;
        dmem.dmem_addr  <= {i_alu_result[ADDR_WIDTH-1:2], 2'b00};
        dmem.dmem_wdata <= in_wdata;
        dmem.dmem_be    <= in_be;
        size_q          <= in_size;
        unsigned_q      <= i_funct3[2];
        off_q           <= in_off;
        addr_q          <= i_alu_result;
        rd_q            <= i_rd;
        reg_write_q     <= ctrl_reg_write;
      end else if (accept) begin
        // ALU passthrough, or a trapped misaligned access that never reaches memory.
        o_valid     <= 1'b1;
        o_result    <= i_alu_result;
        o_rd        <= i_rd;
        o_reg_write <= ctrl_reg_write && !trap;
`ifdef MEM_MISALIGN_TRAP_EN
        o_misaligned <= trap;
`endif
      end else if ((state == BUSY) && dmem.dmem_ack) begin
        o_valid     <= 1'b1;
        o_rd        <= rd_q;
        o_result    <= dmem.dmem_we ? addr_q : load_ext;
        o_reg_write <= dmem.dmem_we ? 1'b0 : reg_write_q;
      end
    end
  end

endmodule
